// File: rtl/alu_cmd_sequencer.sv
// Command sequencer: latches one ALU command at a time, captures the ALU
// response and queues {data, carry, err, tag} in a small circular result FIFO.
module alu_cmd_sequencer #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [3:0]       cmd_sel,
    input  logic [3:0]       cmd_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_result,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic             res_carry,
    output logic             res_err,
    output logic [3:0]       res_tag,
    output logic [CNT_W-1:0] fifo_count,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, STALL} state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       carry;
        logic       err;
        logic [3:0] tag;
    } res_entry_t;

    state_e             state_q, state_d;
    logic [7:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]         alu_sel_q, alu_sel_d, tag_q, tag_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        op_count_q, op_count_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               res_valid_q, res_valid_d;
    res_entry_t         mem_q [DEPTH];
    res_entry_t         push_entry, head;
    logic               accept, push, pop, full;

    // Handshakes and the entry built from the live ALU response
    always_comb begin
        full             = (count_q == CNT_W'(DEPTH));
        pop              = res_valid_q && res_ready;
        accept           = cmd_valid && cmd_ready_q;
        push             = ((state_q == EXEC) || (state_q == STALL)) && (!full || pop);
        push_entry.err   = (alu_sel_q == 4'b0011) && (alu_b_q == 8'h00);
        push_entry.data  = push_entry.err ? 8'hFF : alu_result;
        push_entry.carry = push_entry.err ? 1'b0 : alu_carry;
        push_entry.tag   = tag_q;
    end

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        tag_d       = tag_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d   = cmd_a;
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_sel;
                    tag_d     = cmd_tag;
                    state_d   = EXEC;
                end
            end
            EXEC, STALL: state_d = push ? IDLE : STALL;
            default:     state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end

        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        cmd_ready_d = (state_d == IDLE);
        res_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            tag_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_count_q  <= '0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            tag_q       <= tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            op_count_q  <= op_count_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Storage needs no reset: validity is tracked by the count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign cmd_ready  = cmd_ready_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign res_valid  = res_valid_q;
    assign res_data   = head.data;
    assign res_carry  = head.carry;
    assign res_err    = head.err;
    assign res_tag    = head.tag;
    assign fifo_count = count_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised bench for alu_cmd_sequencer against a transaction-level queue model
// plus a few directed scenarios with hand-computed results.
module tb_alu_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       carry;
        logic       err;
        logic [3:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_a, cmd_b;
    logic [3:0]       cmd_sel, cmd_tag;
    logic [7:0]       alu_a, alu_b;
    logic [3:0]       alu_sel;
    logic [7:0]       alu_result;
    logic             alu_carry;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic             res_carry, res_err;
    logic [3:0]       res_tag;
    logic [CNT_W-1:0] fifo_count;
    logic [15:0]      op_count;

    int vectors = 0;
    int errors  = 0;

    // Model state
    exp_t        fq[$];
    bit          busy = 1'b0;
    exp_t        inflight;
    logic [7:0]  cur_a = '0, cur_b = '0;
    logic [3:0]  cur_sel = '0;
    int unsigned op_cnt = 0;
    bit          last_accept = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_err(res_err), .res_tag(res_tag),
        .fifo_count(fifo_count), .op_count(op_count)
    );

    // Downstream ALU: {carry, result}; divide-by-zero returns junk on purpose
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] sel);
        logic [8:0] r;
        case (sel)
            4'h0: r = {1'b0, a} + {1'b0, b};
            4'h1: r = {1'b0, a} - {1'b0, b};
            4'h2: r = {1'b0, 8'(a * b)};
            4'h3: r = (b == 8'h00) ? 9'h1AB : {1'b0, 8'(a / b)};
            4'h4: r = {1'b0, a & b};
            4'h5: r = {1'b0, a | b};
            4'h6: r = {1'b0, a ^ b};
            4'h7: r = {1'b0, ~a};
            4'h8: r = {a, 1'b0};
            4'h9: r = {a[0], 1'b0, a[7:1]};
            4'hA: r = {1'b0, a} + 9'd1;
            4'hB: r = {1'b0, a} - 9'd1;
            4'hC: r = {1'b0, (a < b) ? 8'd1 : 8'd0};
            4'hD: r = {1'b0, (a > b) ? a : b};
            4'hE: r = {1'b0, ~(a & b)};
            default: r = {1'b0, (a == b) ? 8'd1 : 8'd0};
        endcase
        return r;
    endfunction

    assign {alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_sel);

    function automatic exp_t expect_of(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] sel, input logic [3:0] tag);
        exp_t e;
        logic [8:0] r;
        r = alu_fn(a, b, sel);
        if (sel == 4'h3 && b == 8'h00) begin
            e = '{data: 8'hFF, carry: 1'b0, err: 1'b1, tag: tag};
        end else begin
            e = '{data: r[7:0], carry: r[8], err: 1'b0, tag: tag};
        end
        return e;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void compare();
        chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
        chk("res_valid", 32'(res_valid), 32'(fq.size() != 0));
        chk("fifo_count", 32'(fifo_count), 32'(fq.size()));
        chk("op_count", 32'(op_count), 32'(op_cnt));
        chk("alu_a", 32'(alu_a), 32'(cur_a));
        chk("alu_b", 32'(alu_b), 32'(cur_b));
        chk("alu_sel", 32'(alu_sel), 32'(cur_sel));
        if (fq.size() != 0) begin
            chk("res_data", 32'(res_data), 32'(fq[0].data));
            chk("res_carry", 32'(res_carry), 32'(fq[0].carry));
            chk("res_err", 32'(res_err), 32'(fq[0].err));
            chk("res_tag", 32'(res_tag), 32'(fq[0].tag));
        end
    endfunction

    // One clock: advance the model on the rising edge, compare on the falling edge
    task automatic tick();
        bit pop;
        @(posedge clk);
        last_accept = 1'b0;
        if (rst_n) begin
            pop = (fq.size() != 0) && res_ready;
            if (pop) begin
                void'(fq.pop_front());
            end
            if (busy) begin
                if (fq.size() < DEPTH) begin
                    fq.push_back(inflight);
                    busy = 1'b0;
                    if (op_cnt < 32'hFFFF) op_cnt++;
                end
            end else if (cmd_valid) begin
                inflight    = expect_of(cmd_a, cmd_b, cmd_sel, cmd_tag);
                cur_a       = cmd_a;
                cur_b       = cmd_b;
                cur_sel     = cmd_sel;
                busy        = 1'b1;
                last_accept = 1'b1;
            end
        end
        @(negedge clk);
        compare();
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] sel, input logic [3:0] tag);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_tag = tag;
        do begin
            tick();
            n++;
        end while (!last_accept && n < 50);
        if (!last_accept) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout: tag=%0h not accepted within %0d cycles", tag, n);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fq.delete();
        busy = 1'b0;
        cur_a = '0; cur_b = '0; cur_sel = '0;
        op_cnt = 0;
        #1;
        compare();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_tag = '0;
        res_ready = 1'b0;
        #2;
        do_reset();

        // Simple add, consumer ready
        res_ready = 1'b1;
        send(8'h0A, 8'h02, 4'h0, 4'h3);
        chk("lit_exec_res_valid", 32'(res_valid), 32'd0);
        tick();
        chk("lit_add_valid", 32'(res_valid), 32'd1);
        chk("lit_add_data", 32'(res_data), 32'h0C);
        chk("lit_add_carry", 32'(res_carry), 32'd0);
        chk("lit_add_err", 32'(res_err), 32'd0);
        chk("lit_add_tag", 32'(res_tag), 32'd3);
        tick();

        // Add with carry-out from a fresh reset
        do_reset();
        res_ready = 1'b1;
        send(8'hF6, 8'h0A, 4'h0, 4'h5);
        tick();
        chk("lit_carry_data", 32'(res_data), 32'h00);
        chk("lit_carry_carry", 32'(res_carry), 32'd1);
        chk("lit_carry_opcnt", 32'(op_count), 32'd1);
        tick();

        // Divide by zero
        send(8'h10, 8'h00, 4'h3, 4'h7);
        tick();
        chk("lit_div0_data", 32'(res_data), 32'hFF);
        chk("lit_div0_err", 32'(res_err), 32'd1);
        chk("lit_div0_carry", 32'(res_carry), 32'd0);
        repeat (3) tick();

        // Fill FIFO with consumer stalled, fifth command must stall
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(8'((i << 4) | 1), 8'h01, 4'h0, 4'(8 + i));
        end
        repeat (3) tick();
        chk("lit_full_count", 32'(fifo_count), 32'(DEPTH));
        chk("lit_stall_ready", 32'(cmd_ready), 32'd0);
        chk("lit_stall_alu_a", 32'(alu_a), 32'h41);
        chk("lit_full_head", 32'(res_tag), 32'd8);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("lit_popfull_count", 32'(fifo_count), 32'(DEPTH));
        chk("lit_popfull_head", 32'(res_tag), 32'd9);
        chk("lit_popfull_ready", 32'(cmd_ready), 32'd1);

        // Reset while stalled on a full FIFO
        send(8'h77, 8'h05, 4'h2, 4'hD);
        tick();
        chk("lit_stall2_ready", 32'(cmd_ready), 32'd0);
        do_reset();
        res_ready = 1'b1;
        send(8'h33, 8'h11, 4'h1, 4'h6);
        tick();
        chk("lit_postrst_data", 32'(res_data), 32'h22);
        chk("lit_postrst_tag", 32'(res_tag), 32'd6);
        chk("lit_postrst_opcnt", 32'(op_count), 32'd1);
        tick();

        // Opcode sweep, pointers wrap several times
        do_reset();
        res_ready = 1'b1;
        for (int s = 0; s < 16; s++) begin
            send(8'h0A, 8'h02, 4'(s), 4'(s));
        end
        repeat (4) tick();
        chk("lit_sweep_opcnt", 32'(op_count), 32'd16);
        chk("lit_sweep_count", 32'(fifo_count), 32'd0);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_a     = 8'($urandom);
            cmd_b     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cmd_sel   = ($urandom_range(0, 3) == 0) ? 4'h3 : 4'($urandom);
            cmd_tag   = 4'($urandom);
            res_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
